mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: rdy  in  1  1 = advance microcode this cycle, 0 = stall.
REQ-004 SHALL have port: mc_ctl  in  3  flow op of the current microinstruction (ROM data field).
REQ-005 SHALL have port: mc_target  in  9  branch/jump/call target (ROM data field).
REQ-006 SHALL have port: cond_sel  in  3  index into cond.
REQ-007 SHALL have port: cond  in  8  condition flag vector from datapath.
REQ-008 SHALL have port: ir  in  8  opcode in instruction register.
REQ-009 SHALL have port: irq  in  1  level interrupt request; iflag  in  1  interrupt mask (1 = masked).
REQ-010 SHALL have port: nmi  in  1  non-maskable request, rising-edge triggered.
REQ-011 SHALL have port: addr  out  9  next microcode address to ROM (combinational).
REQ-012 SHALL have port: rom_en  out  1  ROM read enable (= rdy, forced 1 in reset).
REQ-013 SHALL have port: sync  out  1  high in cycles where a DECODE op is executed with rdy=1.
REQ-014 SHALL have port: stk_err  out  1  sticky subroutine-stack fault flag.
REQ-015 SHALL have constants: RST_ENT 9'h170, NMI_ENT 9'h178, IRQ_ENT 9'h17C.

Function
REQ-016 SHALL hold register cur (9 bits) = address of the microinstruction presently on mc_ctl/mc_target; cur <= addr when rdy=1.
REQ-017 SHALL, when rdy=0, drive addr = cur, keep all state, assert sync=0; nmi edge detection continues.
REQ-018 SHALL decode mc_ctl: 0 NEXT addr=cur+1; 1 JUMP addr=mc_target; 2 BRT addr=cond[cond_sel]?mc_target:cur+1; 3 BRF addr=cond[cond_sel]?cur+1:mc_target; 4 DECODE; 5 CALL; 6 RET; 7 HALT addr=cur.
REQ-019 SHALL compute cur+1 modulo 512 (9'h1FF wraps to 9'h000).
REQ-020 SHALL, on DECODE, select by priority: nmi_pend -> NMI_ENT; irq & ~iflag -> IRQ_ENT; else {1'b0, ir}.
REQ-021 SHALL set nmi_pend on cycle where nmi=1 and previous sampled nmi=0; clear it when DECODE with rdy=1 takes NMI_ENT; a new edge in the clearing cycle leaves nmi_pend set.
REQ-022 SHALL implement a 4-entry LIFO of 9-bit return addresses with 3-bit depth counter 0..4.
REQ-023 SHALL on CALL (rdy=1) push cur+1 and set addr=mc_target; at depth 4 the push is dropped, stk_err set, jump still taken.
REQ-024 SHALL on RET (rdy=1) pop and set addr=popped value; at depth 0 set addr=RST_ENT and stk_err, depth stays 0.
REQ-025 SHALL keep stk_err set until reset.
REQ-026 SHALL execute exactly one microinstruction per rdy=1 cycle; addr to ROM has zero-cycle latency from inputs, ROM output valid next cycle.

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge: cur <= RST_ENT, depth <= 0, nmi_pend <= 0, nmi sample <= 0, stk_err <= 0.
REQ-028 SHALL, while reset_n=0, drive addr=RST_ENT, rom_en=1, sync=0 regardless of other inputs.
REQ-029 SHALL, on reset asserted mid-CALL/RET, discard the stack operation; first instruction after release is at RST_ENT.

Configuration
REQ-030 SHALL use macro MC_STACK_EN: defined -> stack, CALL/RET per REQ-022..024.
REQ-031 SHALL, without MC_STACK_EN, contain no stack storage: CALL behaves as JUMP, RET behaves as RET-on-empty (addr=RST_ENT, stk_err set).

Verification
REQ-032 SHALL cover: reset_n=0 two cycles, release, NEXT ops -> addr 9'h170, 9'h171, 9'h172; cur=9'h1FF with NEXT -> addr 9'h000.
REQ-033 SHALL cover: BRT cond_sel=5, cond=8'h20, target 9'h040 -> addr 9'h040; cond=8'h00 -> cur+1; rdy=0 -> addr=cur, no change.
REQ-034 SHALL cover: DECODE ir=8'hA9, irq=1, iflag=1 -> addr 9'h0A9, sync=1; iflag=0 -> addr 9'h17C; nmi pulse earlier -> 9'h178, then next DECODE -> 9'h17C.
REQ-035 SHALL cover (MC_STACK_EN): CALL from cur 9'h010 to 9'h100, RET -> addr 9'h011; five nested CALLs -> stk_err=1; RET at depth 0 -> addr 9'h170, stk_err=1.
REQ-036 SHALL cover (no MC_STACK_EN): CALL target 9'h100 -> addr 9'h100; RET -> addr 9'h170, stk_err=1.
REQ-037 SHALL cover: nmi rising edge during rdy=0 stall, then DECODE with rdy=1 -> addr 9'h178.

Source files
------------

// File: rtl/mc_sequencer.sv
// Microcode sequencer: picks the next microcode ROM address from the current flow op,
// condition flags, the decoded opcode, interrupt/NMI requests and (optionally) a
// return-address stack.
// Latency: addr is combinational from the inputs. The ROM data for addr is expected on
// mc_ctl/mc_target in the next cycle.
// Backpressure: rdy=0 stalls. addr is held at cur, and no state moves except NMI edge capture.
// Build option: define MC_STACK_EN to get the 4-deep CALL/RET stack. Without it, CALL
// acts as JUMP and RET always faults to RST_ENT.
// Ports: clk, reset_n (sync, active-low), rdy, mc_ctl/mc_target (ROM fields),
//        cond_sel/cond (branch condition), ir, irq, iflag, nmi; out: addr, rom_en, sync, stk_err.
module mc_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rdy,
    input  logic [2:0] mc_ctl,
    input  logic [8:0] mc_target,
    input  logic [2:0] cond_sel,
    input  logic [7:0] cond,
    input  logic [7:0] ir,
    input  logic       irq,
    input  logic       iflag,
    input  logic       nmi,
    output logic [8:0] addr,
    output logic       rom_en,
    output logic       sync,
    output logic       stk_err
);

    localparam logic [8:0] RST_ENT = 9'h170;
    localparam logic [8:0] NMI_ENT = 9'h178;
    localparam logic [8:0] IRQ_ENT = 9'h17C;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRT    = 3'd2,
        OP_BRF    = 3'd3,
        OP_DECODE = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_HALT   = 3'd7
    } op_e;

    op_e        op;
    logic [8:0] cur_q, cur_d;
    logic [8:0] cur_inc;
    logic [8:0] addr_run;
    logic       sync_run;
    logic       cond_bit;
    logic       take_nmi;
    logic       nmi_q;
    logic       nmi_pend_q, nmi_pend_d;
    logic       stk_err_q, stk_err_d;

`ifdef MC_STACK_EN
    logic [8:0] stk_q [4];
    logic [2:0] depth_q, depth_d;
    logic [2:0] depth_dec;
    logic       push;

    assign depth_dec = depth_q - 3'd1;
`endif

    assign op       = op_e'(mc_ctl);
    assign cur_inc  = cur_q + 9'd1;   // 9-bit add wraps 1FF -> 000
    assign cond_bit = cond[cond_sel];

    always_comb begin
        addr_run  = cur_q;
        sync_run  = 1'b0;
        take_nmi  = 1'b0;
        stk_err_d = stk_err_q;
`ifdef MC_STACK_EN
        push      = 1'b0;
        depth_d   = depth_q;
`endif
        if (rdy) begin
            case (op)
                OP_NEXT: addr_run = cur_inc;
                OP_JUMP: addr_run = mc_target;
                OP_BRT:  addr_run = cond_bit ? mc_target : cur_inc;
                OP_BRF:  addr_run = cond_bit ? cur_inc : mc_target;
                OP_DECODE: begin
                    sync_run = 1'b1;
                    if (nmi_pend_q) begin
                        addr_run = NMI_ENT;
                        take_nmi = 1'b1;
                    end else if (irq && !iflag) begin
                        addr_run = IRQ_ENT;
                    end else begin
                        addr_run = {1'b0, ir};
                    end
                end
                OP_CALL: begin
                    // The jump is taken even when a full stack drops the push.
                    addr_run = mc_target;
`ifdef MC_STACK_EN
                    if (depth_q == 3'd4) begin
                        stk_err_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + 3'd1;
                    end
`endif
                end
                OP_RET: begin
`ifdef MC_STACK_EN
                    if (depth_q == 3'd0) begin
                        addr_run  = RST_ENT;
                        stk_err_d = 1'b1;
                    end else begin
                        addr_run = stk_q[depth_dec[1:0]];
                        depth_d  = depth_dec;
                    end
`else
                    addr_run  = RST_ENT;
                    stk_err_d = 1'b1;
`endif
                end
                OP_HALT: addr_run = cur_q;
            endcase
        end
    end

    // A fresh NMI edge in the same cycle that a pending NMI is taken keeps it pending.
    assign nmi_pend_d = (nmi_pend_q & ~take_nmi) | (nmi & ~nmi_q);

    assign addr    = reset_n ? addr_run : RST_ENT;
    assign rom_en  = reset_n ? rdy : 1'b1;
    assign sync    = reset_n & sync_run;
    assign stk_err = stk_err_q;
    assign cur_d   = addr;   // equals cur_q when stalled

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_q      <= RST_ENT;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            nmi_q      <= nmi;
            nmi_pend_q <= nmi_pend_d;
            stk_err_q  <= stk_err_d;
        end
    end

`ifdef MC_STACK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q <= 3'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Return-address storage needs no reset: the depth counter qualifies every read.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            stk_q[depth_q[1:0]] <= cur_inc;
        end
    end
`endif

endmodule
